// File: rtl/serial_alu_pkg.sv
// ISA definitions shared by the serial ALU and any future parallel ALU:
// operation encodings, packet layout and the serial ALU state encoding.
package serial_alu_pkg;

  localparam int REGISTER_SIZE       = 32;
  localparam int ALU_OPERATION_COUNT = 4;
  localparam int ALU_OPERAND_WIDTH   = REGISTER_SIZE + 1;
  localparam int ALU_OPCODE_WIDTH    = $clog2(ALU_OPERATION_COUNT);

  typedef enum logic [ALU_OPCODE_WIDTH-1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } AluOperation;

  // Last member sits at the LSBs, so op_code is the first bit on the wire.
  typedef struct packed {
    logic [ALU_OPERAND_WIDTH-1:0] op_2;
    logic [ALU_OPERAND_WIDTH-1:0] op_1;
    AluOperation                  op_code;
  } AluPacket;

  localparam int ALU_PACKET_WIDTH = $bits(AluPacket);

  typedef enum logic [1:0] {
    RECEIVE,
    EXECUTE,
    TRANSMIT
  } SerialAluState;

endpackage

// File: rtl/serial_alu_if.sv
// Bit-serial packet-in / result-out handshake bundle of the serial ALU.
interface serial_alu_if;

  logic rx_valid;
  logic rx_data;
  logic rx_ready;
  logic tx_valid;
  logic tx_data;
  logic tx_last;
  logic tx_ready;
  logic busy;

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  rx_ready, tx_valid, tx_data, tx_last, busy
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output rx_ready, tx_valid, tx_data, tx_last, busy
  );

endinterface

// File: rtl/serial_alu_core.sv
// Combinational ALU datapath; arithmetic wraps modulo 2^WIDTH.
module serial_alu_core
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = ALU_OPERAND_WIDTH
) (
  input  AluOperation      op_i,
  input  logic [WIDTH-1:0] op_1_i,
  input  logic [WIDTH-1:0] op_2_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = op_1_i + op_2_i;
      ALU_SUB: result_o = op_1_i - op_2_i;
      ALU_AND: result_o = op_1_i & op_2_i;
      ALU_OR:  result_o = op_1_i | op_2_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Serial execution stage: shifts in one AluPacket LSB first, executes it in
// one cycle, then shifts the result out LSB first under tx handshake.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int OPERAND_WIDTH = ALU_OPERAND_WIDTH,
  parameter int OPCODE_WIDTH  = $clog2(ALU_OPERATION_COUNT)
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_alu_if.slave  alu_if
);

  localparam int PACKET_WIDTH = OPCODE_WIDTH + 2 * OPERAND_WIDTH;
  localparam int CNT_W        = $clog2(PACKET_WIDTH);
  localparam int RES_IDX_W    = $clog2(OPERAND_WIDTH);

  localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PACKET_WIDTH - 1);
  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(OPERAND_WIDTH - 1);

  SerialAluState              state_q, state_d;
  logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [PACKET_WIDTH-1:0]    pkt_q, pkt_d;
  logic [OPERAND_WIDTH-1:0]   result_q, result_d;
  logic [OPERAND_WIDTH-1:0]   alu_result;
  AluPacket                   pkt;
  logic                       in_tx;

  assign pkt = AluPacket'(pkt_q);

  serial_alu_core #(
    .WIDTH (OPERAND_WIDTH)
  ) u_core (
    .op_i     (pkt.op_code),
    .op_1_i   (pkt.op_1),
    .op_2_i   (pkt.op_2),
    .result_o (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RECEIVE;
      bit_cnt_q <= '0;
      pkt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pkt_q     <= pkt_d;
      result_q  <= result_d;
    end
  end

  // One counter serves both directions; it is cleared on every state exit.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pkt_d     = pkt_q;
    result_d  = result_q;
    case (state_q)
      RECEIVE: begin
        if (alu_if.rx_valid) begin
          pkt_d[bit_cnt_q] = alu_if.rx_data;
          if (bit_cnt_q == PKT_LAST) begin
            bit_cnt_d = '0;
            state_d   = EXECUTE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      EXECUTE: begin
        result_d = alu_result;
        state_d  = TRANSMIT;
      end
      TRANSMIT: begin
        if (alu_if.tx_ready) begin
          if (bit_cnt_q == RES_LAST) begin
            bit_cnt_d = '0;
            state_d   = RECEIVE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = RECEIVE;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign in_tx           = (state_q == TRANSMIT);
  assign alu_if.rx_ready = (state_q == RECEIVE);
  assign alu_if.busy     = (state_q != RECEIVE);
  assign alu_if.tx_valid = in_tx;
  assign alu_if.tx_data  = in_tx & result_q[bit_cnt_q[RES_IDX_W-1:0]];
  assign alu_if.tx_last  = in_tx && (bit_cnt_q == RES_LAST);

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: vector table plus reset/stall/gap sequences.
module tb_serial_alu;
  import serial_alu_pkg::*;

  localparam int OW = ALU_OPERAND_WIDTH;
  localparam int PW = ALU_PACKET_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  serial_alu_if bus ();

  serial_alu #(
    .OPERAND_WIDTH (OW),
    .OPCODE_WIDTH  (ALU_OPCODE_WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .alu_if (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    AluOperation   op;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(AluOperation op, logic [OW-1:0] a, logic [OW-1:0] b);
    return {b, a, op};
  endfunction

  task automatic send_pkt(input AluOperation op, input logic [OW-1:0] a, input logic [OW-1:0] b,
                          input bit gaps, input bit hold, output bit first_ready);
    logic [PW-1:0] p;
    int i;
    int cyc;
    p = pack(op, a, b);
    i = 0;
    cyc = 0;
    first_ready = 1'b0;
    while (i < PW) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) first_ready = bus.rx_ready;
      if (cyc > 4 * PW) begin
        check("send_timeout", 64'(i), 64'(PW));
        bus.rx_valid = 1'b0;
        return;
      end
      if (gaps && (cyc % 2 == 0)) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 1'b0;
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = p[i];
        if (bus.rx_ready) i++;
      end
    end
    @(negedge clk);
    if (hold) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 1'b1;
    end else begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 1'b0;
    end
  endtask

  task automatic recv_result(input bit hold, input int stall_at, output logic [OW-1:0] res,
                             output int first_wait, output int last_pos,
                             output bit hold_ok, output bit stable_ok);
    int idx;
    int cyc;
    int stall_cnt;
    bit stalled;
    logic data_h;
    logic last_h;
    idx = 0; cyc = 0; stall_cnt = 0; stalled = 1'b0;
    data_h = 1'b0; last_h = 1'b0;
    res = '0; first_wait = -1; last_pos = -1; hold_ok = 1'b1; stable_ok = 1'b1;
    bus.tx_ready = 1'b1;
    while (idx < OW) begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        check("recv_timeout", 64'(idx), 64'(OW));
        bus.tx_ready = 1'b1;
        bus.rx_valid = 1'b0;
        return;
      end
      if (hold && bus.rx_ready) hold_ok = 1'b0;
      if (!bus.tx_valid) continue;
      if (first_wait < 0) first_wait = cyc;
      if (stall_cnt > 0) begin
        if (bus.tx_data !== data_h || bus.tx_last !== last_h) stable_ok = 1'b0;
        stall_cnt--;
        if (stall_cnt > 0) continue;
        bus.tx_ready = 1'b1;
      end else if (!stalled && idx == stall_at) begin
        stalled      = 1'b1;
        bus.tx_ready = 1'b0;
        data_h       = bus.tx_data;
        last_h       = bus.tx_last;
        stall_cnt    = 5;
        continue;
      end
      res[idx] = bus.tx_data;
      if (bus.tx_last) last_pos = (last_pos < 0) ? idx : 99;
      idx++;
      if (idx == OW && hold) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 1'b0;
      end
    end
  endtask

  task automatic run_vec(input string name, input AluOperation op, input logic [OW-1:0] a,
                         input logic [OW-1:0] b, input logic [OW-1:0] exp,
                         input bit gaps, input bit hold, input int stall_at);
    logic [OW-1:0] res;
    int first_wait, last_pos;
    bit hold_ok, stable_ok, first_ready;
    send_pkt(op, a, b, gaps, hold, first_ready);
    check({name, "_rx_ready_at_start"}, 64'(first_ready), 64'(1));
    check({name, "_exec_tx_valid"}, 64'(bus.tx_valid), 64'(0));
    check({name, "_exec_busy"}, 64'(bus.busy), 64'(1));
    recv_result(hold, stall_at, res, first_wait, last_pos, hold_ok, stable_ok);
    check({name, "_latency"}, 64'(first_wait), 64'(1));
    check({name, "_result"}, 64'(res), 64'(exp));
    check({name, "_tx_last_pos"}, 64'(last_pos), 64'(OW - 1));
    if (hold) check({name, "_rx_ready_low"}, 64'(hold_ok), 64'(1));
    if (stall_at >= 0) check({name, "_stall_stable"}, 64'(stable_ok), 64'(1));
  endtask

  initial begin
    logic [PW-1:0] p;

    vecs[0] = '{ALU_ADD, 33'd5,            33'd7,            33'd12};
    vecs[1] = '{ALU_SUB, 33'd0,            33'd1,            33'h1_FFFF_FFFF};
    vecs[2] = '{ALU_AND, 33'h0_0000_F0F0,  33'h0_0000_FF00,  33'h0_0000_F000};
    vecs[3] = '{ALU_OR,  33'h0_0000_F0F0,  33'h0_0000_FF00,  33'h0_0000_FFF0};
    vecs[4] = '{ALU_ADD, 33'h1_FFFF_FFFF,  33'd1,            33'd0};
    vecs[5] = '{ALU_SUB, 33'd5,            33'd7,            33'h1_FFFF_FFFE};
    vecs[6] = '{ALU_AND, 33'h1_2345_6789,  33'h0_FFFF_0000,  33'h0_2345_0000};
    vecs[7] = '{ALU_OR,  33'h1_0000_0000,  33'h0_0000_00FF,  33'h1_0000_00FF};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 1'b0;
    bus.tx_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_rx_ready", 64'(bus.rx_ready), 64'(1));
    check("reset_tx_valid", 64'(bus.tx_valid), 64'(0));
    check("reset_tx_data",  64'(bus.tx_data),  64'(0));
    check("reset_tx_last",  64'(bus.tx_last),  64'(0));
    check("reset_busy",     64'(bus.busy),     64'(0));
    rst_n = 1'b1;

    // Table vectors run back-to-back: each send starts right after tx_last.
    for (int k = 0; k < 8; k++)
      run_vec($sformatf("vec%0d", k), vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].exp, 1'b0, 1'b0, -1);

    run_vec("gap_stall_add", ALU_ADD, 33'h1_0000_0000, 33'h1_0000_0000, 33'd0, 1'b1, 1'b0, 10);
    run_vec("gap_stall_sub", ALU_SUB, 33'd0, 33'd1, 33'h1_FFFF_FFFF, 1'b1, 1'b0, 10);

    run_vec("hold_add", ALU_ADD, 33'h0F, 33'h01, 33'h10, 1'b0, 1'b1, -1);
    run_vec("after_hold_sub", ALU_SUB, 33'd10, 33'd3, 33'd7, 1'b0, 1'b0, -1);

    // Reset after 30 received bits, then a clean packet.
    p = pack(ALU_ADD, 33'h1_2345_6789, 33'h0_ABCD_EF01);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = p[i];
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_rx_rx_ready", 64'(bus.rx_ready), 64'(1));
    check("rst_rx_busy",     64'(bus.busy),     64'(0));
    check("rst_rx_tx_valid", 64'(bus.tx_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst_or", ALU_OR, 33'd3, 33'd4, 33'd7, 1'b0, 1'b0, -1);

    // Reset in the middle of transmitting a result.
    begin
      bit fr;
      send_pkt(ALU_SUB, 33'd0, 33'd1, 1'b0, 1'b0, fr);
      repeat (5) @(negedge clk);
      check("mid_tx_tx_valid", 64'(bus.tx_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      check("rst_tx_tx_valid", 64'(bus.tx_valid), 64'(0));
      check("rst_tx_tx_data",  64'(bus.tx_data),  64'(0));
      check("rst_tx_tx_last",  64'(bus.tx_last),  64'(0));
      check("rst_tx_busy",     64'(bus.busy),     64'(0));
      @(negedge clk);
      check("rst_tx_no_residual", 64'(bus.tx_valid), 64'(0));
      rst_n = 1'b1;
    end
    run_vec("post_rst_and", ALU_AND, 33'h1_FFFF_0000, 33'h1_0F0F_FFFF, 33'h1_0F0F_0000, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
